pwm_dac: RTL and testbench

- Downstream consumer of the NCO sample stream. Turns each WIDTH-bit unsigned sample into a pulse-width-modulated single-bit output suitable for an RC-filtered pin or an LED.
- Samples enter through a one-entry valid/ready buffer and are applied only at PWM period boundaries, so every period is glitch-free.
- Underruns (no new sample by a boundary) are flagged and counted for bring-up debug.

---
 rtl/pwm_dac.sv | 74 +++++++
 tb/tb_pwm_dac.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pwm_dac.sv
// PWM DAC: buffers one NCO sample and applies it only at period boundaries.
// Boundaries that find the buffer empty raise underrun and bump a saturating count.
module pwm_dac #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1,
  parameter int UCOUNT_W = 8
) (
  input  logic                pll_clock,
  input  logic                reset,
  input  logic [WIDTH-1:0]    sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                pwm_out,
  output logic                period_start,
  output logic                underrun,
  output logic [UCOUNT_W-1:0] underrun_count
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = '1;
  localparam logic [UCOUNT_W-1:0] UCNT_MAX = '1;

  logic [PW-1:0]    pre_cnt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] active_duty;
  logic [WIDTH-1:0] pend_sample;
  logic             pending;
  logic             tick;
  logic             boundary;
  logic             accept;

  assign tick         = (pre_cnt == PRE_LAST);
  assign boundary     = tick && (cnt == CNT_LAST);
  assign sample_ready = !pending;
  assign accept       = sample_valid && !pending;

  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      pre_cnt        <= '0;
      cnt            <= '0;
      active_duty    <= '0;
      pend_sample    <= '0;
      pending        <= 1'b0;
      pwm_out        <= 1'b0;
      period_start   <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick)
        cnt <= cnt + WIDTH'(1);

      // accept only fires while empty, consume only while full
      if (accept) begin
        pend_sample <= sample_in;
        pending     <= 1'b1;
      end

      if (boundary && pending) begin
        active_duty <= pend_sample;
        pending     <= 1'b0;
      end

      if (boundary && !pending && underrun_count != UCNT_MAX)
        underrun_count <= underrun_count + UCOUNT_W'(1);

      underrun     <= boundary && !pending;
      period_start <= boundary;
      pwm_out      <= (cnt < active_duty);
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac (WIDTH=4, PRESCALE=1, UCOUNT_W=3).
// Each window is 16 clocks; its last step is the boundary.
module tb_pwm_dac;

  logic       pll_clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       pwm_out;
  logic       period_start;
  logic       underrun;
  logic [2:0] underrun_count;

  int checks = 0;
  int errors = 0;

  pwm_dac #(.WIDTH(4), .PRESCALE(1), .UCOUNT_W(3)) dut (
    .pll_clock      (pll_clock),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .pwm_out        (pwm_out),
    .period_start   (period_start),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #5 pll_clock = ~pll_clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pll_clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pwm"}, 32'(pwm_out), 0);
    chk({tag, "_ps"}, 32'(period_start), 0);
    chk({tag, "_ur"}, 32'(underrun), 0);
    chk({tag, "_ucnt"}, 32'(underrun_count), 0);
    chk({tag, "_rdy"}, 32'(sample_ready), 1);
  endtask

  task automatic do_reset(input string tag);
    step();
    sample_valid = 1'b0;
    reset = 1'b1;
    step();
    step();
    check_reset_outputs(tag);
    reset = 1'b0;
  endtask

  // mode: 0 idle, 1 single sample at index 0, 2 valid held all window
  task automatic run_window(input string tag, input int mode,
                            input logic [3:0] val, input int exp_high,
                            input bit exp_under, input int exp_cnt);
    for (int i = 0; i < 16; i++) begin
      sample_valid = (mode == 2) || (mode == 1 && i == 0);
      sample_in    = val + 4'(i);
      step();
      chk($sformatf("%s_pwm%0d", tag, i), 32'(pwm_out),
          32'(i < exp_high));
      chk($sformatf("%s_ps%0d", tag, i), 32'(period_start),
          32'(i == 15));
      chk($sformatf("%s_ur%0d", tag, i), 32'(underrun),
          32'(i == 15 && exp_under));
      chk($sformatf("%s_rdy%0d", tag, i), 32'(sample_ready),
          32'((i == 15) || mode == 0));
    end
    sample_valid = 1'b0;
    chk({tag, "_ucnt"}, 32'(underrun_count), 32'(exp_cnt));
  endtask

  initial begin
    #2;
    check_reset_outputs("por");
    do_reset("rst1");

    // idle: underrun every period, pwm stays low
    run_window("idle0", 0, 4'd0, 0, 1, 1);
    run_window("idle1", 0, 4'd0, 0, 1, 2);
    run_window("idle2", 0, 4'd0, 0, 1, 3);

    // single samples, one per period
    do_reset("rst2");
    run_window("s5",   1, 4'd5,  0,  0, 0);
    run_window("s10a", 1, 4'd10, 5,  0, 0);
    run_window("s10b", 1, 4'd10, 10, 0, 0);
    run_window("s0",   1, 4'd0,  10, 0, 0);
    run_window("s15",  1, 4'd15, 0,  0, 0);
    run_window("h15a", 0, 4'd0,  15, 1, 1);
    run_window("h15b", 0, 4'd0,  15, 1, 2);

    // valid held high: only the index-0 value of each window is taken
    do_reset("rst3");
    run_window("hold3",  2, 4'd3,  0,  0, 0);
    run_window("hold9",  2, 4'd9,  3,  0, 0);
    run_window("hold12", 2, 4'd12, 9,  0, 0);
    run_window("hold_e", 0, 4'd0,  12, 1, 1);

    // saturating underrun counter
    do_reset("rst4");
    for (int w = 1; w <= 10; w++)
      run_window($sformatf("sat%0d", w), 0, 4'd0, 0, 1,
                 (w < 7) ? w : 7);
    run_window("sat_f15", 1, 4'd15, 0, 0, 7);

    // mid-period reset with a pending sample and pwm high
    sample_valid = 1'b1;
    sample_in = 4'd7;
    step();
    sample_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_pwm", 32'(pwm_out), 1);
    chk("mid_rdy", 32'(sample_ready), 0);
    chk("mid_ucnt", 32'(underrun_count), 7);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    step();
    reset = 1'b0;
    run_window("post0", 0, 4'd0, 0, 1, 1);
    run_window("post1", 0, 4'd0, 0, 1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
